release_sched: RTL and testbench



---
 rtl/release_sched_pkg.sv | 12 +
 rtl/rel_compact.sv | 30 +++
 rtl/release_sched.sv | 99 +++++++++
 tb/tb_release_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/release_sched_pkg.sv
// Shared constants for the tag-release scheduler.
// Tag widths for the physical-tag and issue-queue freelist instances.
package release_sched_pkg;

  localparam int FREE_SEL_PREG = 6;
  localparam int FREE_SEL_IQ   = 5;

  localparam int MAX_REL_IN  = 4;
  localparam int MAX_REL_OUT = 2;
  localparam int REL_CNT_W   = $clog2(MAX_REL_IN + 1);

endpackage

// File: rtl/rel_compact.sv
// Packs up to four valid/tag pairs into a hole-free list.
// Slot order is oldest first: input index 0 lands first.
module rel_compact
  import release_sched_pkg::*;
#(
  parameter int W = FREE_SEL_PREG
) (
  input  logic [MAX_REL_IN-1:0] valid,
  input  logic [W-1:0]          tag  [MAX_REL_IN],
  output logic [W-1:0]          list [MAX_REL_IN],
  output logic [REL_CNT_W-1:0]  num
);

  int cnt;

  always_comb begin
    cnt = 0;
    for (int i = 0; i < MAX_REL_IN; i++) begin
      list[i] = '0;
    end
    for (int i = 0; i < MAX_REL_IN; i++) begin
      if (valid[i]) begin
        list[cnt[1:0]] = tag[i];
        cnt = cnt + 1;
      end
    end
    num = REL_CNT_W'(cnt);
  end

endmodule

// File: rtl/release_sched.sv
// Buffers up to four freed tags per cycle and drains two
// per cycle onto the freelist release ports, in order.
module release_sched
  import release_sched_pkg::*;
#(
  parameter int FREE_SEL = FREE_SEL_PREG,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FREE_SEL-1:0] commit_tag_1,
  input  logic [FREE_SEL-1:0] commit_tag_2,
  input  logic                commit_valid_1,
  input  logic                commit_valid_2,
  input  logic [FREE_SEL-1:0] squash_tag_1,
  input  logic [FREE_SEL-1:0] squash_tag_2,
  input  logic                squash_valid_1,
  input  logic                squash_valid_2,
  output logic                in_ready,
  output logic [FREE_SEL-1:0] released_1,
  output logic [FREE_SEL-1:0] released_2,
  output logic                released_valid_1,
  output logic                released_valid_2,
  output logic [PTR_W:0]      pending,
  output logic                overflow
);

  logic [FREE_SEL-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [PTR_W:0]        count_q;
  logic                  overflow_q;

  logic [MAX_REL_IN-1:0] in_valid;
  logic [FREE_SEL-1:0]   in_tag   [MAX_REL_IN];
  logic [FREE_SEL-1:0]   cmp_list [MAX_REL_IN];
  logic [REL_CNT_W-1:0]  cmp_num;
  logic [REL_CNT_W-1:0]  pushed;
  logic [PTR_W:0]        drained;
  logic [PTR_W-1:0]      head_p1;

  assign in_valid = {squash_valid_2, squash_valid_1,
                     commit_valid_2, commit_valid_1};
  assign in_tag[0] = commit_tag_1;
  assign in_tag[1] = commit_tag_2;
  assign in_tag[2] = squash_tag_1;
  assign in_tag[3] = squash_tag_2;

  rel_compact #(.W(FREE_SEL)) u_compact (
    .valid (in_valid),
    .tag   (in_tag),
    .list  (cmp_list),
    .num   (cmp_num)
  );

  // Drain is unconditional: the freelist never back-pressures.
  assign drained =
    (count_q >= (PTR_W+1)'(MAX_REL_OUT)) ?
    (PTR_W+1)'(MAX_REL_OUT) : count_q;

  assign in_ready =
    (count_q - drained) <= (PTR_W+1)'(DEPTH - MAX_REL_IN);

  assign pushed  = in_ready ? cmp_num : '0;
  assign head_p1 = head_q + PTR_W'(1);

  assign released_valid_1 = (count_q >= (PTR_W+1)'(1));
  assign released_valid_2 = (count_q >= (PTR_W+1)'(2));
  assign released_1 = released_valid_1 ? mem_q[head_q]  : '0;
  assign released_2 = released_valid_2 ? mem_q[head_p1] : '0;
  assign pending    = count_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q  <= head_q + drained[PTR_W-1:0];
      tail_q  <= tail_q + PTR_W'(pushed);
      count_q <= count_q - drained + (PTR_W+1)'(pushed);
      if (!in_ready && (in_valid != '0)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_REL_IN; k++) begin
      if (k < int'(pushed)) begin
        mem_q[tail_q + PTR_W'(k)] <= cmp_list[k];
      end
    end
  end

endmodule

// File: tb/tb_release_sched.sv
// Scoreboard bench for release_sched: a tag queue models the
// FIFO, outputs are compared at the falling edge.
module tb_release_sched;
  import release_sched_pkg::*;

  localparam int W     = 6;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ct1, ct2, st1, st2;
  logic          cv1, cv2, sv1, sv2;
  logic          in_ready;
  logic [W-1:0]  r1, r2;
  logic          rv1, rv2;
  logic [PW:0]   pending;
  logic          overflow;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] q[$];
  logic         ov_m = 1'b0;

  release_sched #(.FREE_SEL(W), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk              (clk),
    .reset            (reset),
    .commit_tag_1     (ct1),
    .commit_tag_2     (ct2),
    .commit_valid_1   (cv1),
    .commit_valid_2   (cv2),
    .squash_tag_1     (st1),
    .squash_tag_2     (st2),
    .squash_valid_1   (sv1),
    .squash_valid_2   (sv2),
    .in_ready         (in_ready),
    .released_1       (r1),
    .released_2       (r2),
    .released_valid_1 (rv1),
    .released_valid_2 (rv2),
    .pending          (pending),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic apply(input logic [3:0] v,
                       input logic [W-1:0] t0, t1, t2, t3);
    int cnt;
    int dr;
    bit rdy;
    cnt = q.size();
    dr  = (cnt > 2) ? 2 : cnt;
    rdy = (cnt - dr) <= (DEPTH - 4);
    {sv2, sv1, cv2, cv1} = v;
    ct1 = t0; ct2 = t1; st1 = t2; st2 = t3;
    @(posedge clk);
    repeat (dr) void'(q.pop_front());
    if (rdy) begin
      if (v[0]) q.push_back(t0);
      if (v[1]) q.push_back(t1);
      if (v[2]) q.push_back(t2);
      if (v[3]) q.push_back(t3);
    end else if (v != 4'b0) begin
      ov_m = 1'b1;
    end
    @(negedge clk);
    {sv2, sv1, cv2, cv1} = 4'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {sv2, sv1, cv2, cv1} = 4'b0;
    ct1 = '0; ct2 = '0; st1 = '0; st2 = '0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rv1 !== 1'b0) $display("FAIL rst_rv1: got %b want 0", rv1);
    else passes++;
    checks++;
    if (rv2 !== 1'b0) $display("FAIL rst_rv2: got %b want 0", rv2);
    else passes++;
    checks++;
    if (pending !== '0) $display("FAIL rst_pending: got %0d want 0", pending);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
    else passes++;
    checks++;
    if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow);
    else passes++;
  endtask

  task automatic test_single;
    apply(4'b0001, 6'd7, '0, '0, '0);
    checks++;
    if (r1 !== 6'd7 || rv1 !== 1'b1 || rv2 !== 1'b0)
      $display("FAIL single_out: got r1=%0d v1=%b v2=%b want 7 1 0",
               r1, rv1, rv2);
    else passes++;
    checks++;
    if (pending !== 4'd1) $display("FAIL single_pend1: got %0d want 1", pending);
    else passes++;
    apply(4'b0000, '0, '0, '0, '0);
    checks++;
    if (pending !== 4'd0 || rv1 !== 1'b0)
      $display("FAIL single_pend0: got %0d v1=%b want 0 0", pending, rv1);
    else passes++;
  endtask

  task automatic test_compact;
    apply(4'b0110, 6'd0, 6'd3, 6'd9, 6'd0);
    checks++;
    if (r1 !== 6'd3 || r2 !== 6'd9 || rv1 !== 1'b1 || rv2 !== 1'b1)
      $display("FAIL compact: got %0d/%0d v=%b%b want 3/9 v=11",
               r1, r2, rv1, rv2);
    else passes++;
    apply(4'b0000, '0, '0, '0, '0);
  endtask

  // Checks current outputs against the model head, then idles until empty.
  task automatic drain_all(input string nm);
    int guard;
    guard = 0;
    while ((q.size() > 0 || pending != 0) && guard < 20) begin
      checks++;
      if (rv1 !== (q.size() >= 1) || rv2 !== (q.size() >= 2) ||
          (q.size() >= 1 && r1 !== q[0]) ||
          (q.size() >= 2 && r2 !== q[1]) ||
          pending !== (PW+1)'(q.size()))
        $display("FAIL %s_drain: got r=%0d/%0d v=%b%b pend=%0d want size %0d",
                 nm, r1, r2, rv1, rv2, pending, q.size());
      else passes++;
      apply(4'b0000, '0, '0, '0, '0);
      guard++;
    end
    checks++;
    if (guard >= 20 || pending !== '0)
      $display("FAIL %s_empty: got pend=%0d want 0", nm, pending);
    else passes++;
  endtask

  task automatic test_burst;
    apply(4'hF, 6'd0, 6'd1, 6'd2, 6'd3);
    checks++;
    if (pending !== 4'd4 || r1 !== 6'd0 || r2 !== 6'd1 || in_ready !== 1'b1)
      $display("FAIL burst1: got p=%0d r=%0d/%0d rdy=%b want 4 0/1 1",
               pending, r1, r2, in_ready);
    else passes++;
    apply(4'hF, 6'd4, 6'd5, 6'd6, 6'd7);
    checks++;
    if (pending !== 4'd6 || r1 !== 6'd2 || r2 !== 6'd3 || in_ready !== 1'b1)
      $display("FAIL burst2: got p=%0d r=%0d/%0d rdy=%b want 6 2/3 1",
               pending, r1, r2, in_ready);
    else passes++;
    apply(4'hF, 6'd8, 6'd9, 6'd10, 6'd11);
    checks++;
    if (pending !== 4'd8 || r1 !== 6'd4 || r2 !== 6'd5 || in_ready !== 1'b0)
      $display("FAIL burst3: got p=%0d r=%0d/%0d rdy=%b want 8 4/5 0",
               pending, r1, r2, in_ready);
    else passes++;
    drain_all("burst");
  endtask

  task automatic test_overflow;
    apply(4'hF, 6'd20, 6'd21, 6'd22, 6'd23);
    apply(4'hF, 6'd24, 6'd25, 6'd26, 6'd27);
    apply(4'hF, 6'd28, 6'd29, 6'd30, 6'd31);
    checks++;
    if (in_ready !== 1'b0 || overflow !== 1'b0)
      $display("FAIL ovf_full: got rdy=%b ovf=%b want 0 0", in_ready, overflow);
    else passes++;
    apply(4'b0001, 6'd33, '0, '0, '0);
    checks++;
    if (overflow !== 1'b1 || pending !== 4'd6)
      $display("FAIL ovf_set: got ovf=%b p=%0d want 1 6", overflow, pending);
    else passes++;
    drain_all("ovf");
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    ov_m = 1'b0;
    q.delete();
  endtask

  task automatic test_wrap;
    logic [3:0] v;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rv1 !== (q.size() >= 1) || rv2 !== (q.size() >= 2) ||
          (q.size() >= 1 && r1 !== q[0]) ||
          (q.size() >= 2 && r2 !== q[1]) ||
          pending !== (PW+1)'(q.size()) || overflow !== ov_m)
        $display("FAIL wrap_%0d: got r=%0d/%0d v=%b%b p=%0d ovf=%b want n=%0d ovf=%b",
                 i, r1, r2, rv1, rv2, pending, overflow, q.size(), ov_m);
      else passes++;
      v = 4'($urandom_range(0, 15));
      apply(v, 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
    end
    drain_all("wrap");
  endtask

  task automatic test_reset_mid_drain;
    apply(4'hF, 6'd40, 6'd41, 6'd42, 6'd43);
    apply(4'b0111, 6'd44, 6'd45, 6'd46, 6'd0);
    apply(4'b0001, 6'd1, '0, '0, '0);
    apply(4'b1111, 6'd2, 6'd3, 6'd4, 6'd5);
    apply(4'b1111, 6'd6, 6'd7, 6'd8, 6'd9);
    apply(4'b0001, 6'd10, '0, '0, '0);
    checks++;
    if (overflow !== 1'b1)
      $display("FAIL mid_pre_ovf: got %b want 1", overflow);
    else passes++;
    q.delete();
    ov_m = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(4'hF, 6'd40, 6'd41, 6'd42, 6'd43);
    apply(4'b0111, 6'd44, 6'd45, 6'd46, 6'd0);
    checks++;
    if (pending !== 4'd5 || r1 !== 6'd42)
      $display("FAIL mid_pend: got p=%0d r1=%0d want 5 42", pending, r1);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rv1 !== 1'b0 || rv2 !== 1'b0 || r1 !== '0 || r2 !== '0)
      $display("FAIL mid_rel: got v=%b%b r=%0d/%0d want 00 0/0",
               rv1, rv2, r1, r2);
    else passes++;
    checks++;
    if (pending !== '0 || in_ready !== 1'b1 || overflow !== 1'b0)
      $display("FAIL mid_state: got p=%0d rdy=%b ovf=%b want 0 1 0",
               pending, in_ready, overflow);
    else passes++;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_compact;
    test_burst;
    test_overflow;
    test_wrap;
    test_reset_mid_drain;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
